// File: rtl/sr_axi_mem_responder_if.sv
// AXI request/response struct pair for the memory responder, bundled with
// initiator (master) and responder (slave) views.
interface sr_axi_mem_responder_if #(
    parameter int ID_W_WIDTH     = 4,
    parameter int ID_R_WIDTH     = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int AXI_DATA_WIDTH = 8
);
    typedef struct packed {
        logic [ID_W_WIDTH-1:0]     awid;
        logic [ADDR_WIDTH-1:0]     awaddr;
        logic [7:0]                awlen;
        logic [1:0]                awburst;
        logic                      awvalid;
        logic [AXI_DATA_WIDTH-1:0] wdata;
        logic                      wstrb;
        logic                      wlast;
        logic                      wvalid;
        logic                      bready;
        logic [ID_R_WIDTH-1:0]     arid;
        logic [ADDR_WIDTH-1:0]     araddr;
        logic [7:0]                arlen;
        logic [1:0]                arburst;
        logic                      arvalid;
        logic                      rready;
    } axi_mosi_t;

    typedef struct packed {
        logic                      awready;
        logic                      wready;
        logic [ID_W_WIDTH-1:0]     bid;
        logic [1:0]                bresp;
        logic                      bvalid;
        logic                      arready;
        logic [ID_R_WIDTH-1:0]     rid;
        logic [AXI_DATA_WIDTH-1:0] rdata;
        logic [1:0]                rresp;
        logic                      rlast;
        logic                      rvalid;
    } axi_miso_t;

    axi_mosi_t in_mosi_i;
    axi_miso_t out_miso_o;

    modport master (output in_mosi_i, input out_miso_o);
    modport slave  (input in_mosi_i, output out_miso_o);
endinterface

// File: rtl/sr_axi_mem_responder.sv
// AXI slave endpoint storing bytes locally; independent write and read FSMs.
// Optional SLV_BACKPRESSURE_EN adds LFSR-driven WREADY/RVALID throttling.
module sr_axi_mem_responder #(
    parameter int ID_W_WIDTH     = 4,
    parameter int ID_R_WIDTH     = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int AXI_DATA_WIDTH = 8,
    parameter int MEM_DEPTH      = 4096
) (
    input logic                  clk,
    input logic                  rst,
    sr_axi_mem_responder_if.slave axi
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i, input logic fixed);
        return fixed ? i : i + 1'b1;
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic                      mem_we;
    logic [IDX_W-1:0]          mem_waddr;
    logic [AXI_DATA_WIDTH-1:0] mem_wdata;

    wstate_e               wstate_q, wstate_d;
    logic [ID_W_WIDTH-1:0] wid_q, wid_d;
    logic [IDX_W-1:0]      widx_q, widx_d;
    logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic                  wfixed_q, wfixed_d, werr_q, werr_d, wover_q, wover_d;
    logic                  awready, wready, bvalid;

    rstate_e                   rstate_q, rstate_d;
    logic [ID_R_WIDTH-1:0]     rid_q, rid_d;
    logic [IDX_W-1:0]          ridx_q, ridx_d;
    logic [7:0]                rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic                      rfixed_q, rfixed_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      arready;
    logic [IDX_W-1:0]          rnext;

    logic wready_ok, rvalid_ok;

`ifdef SLV_BACKPRESSURE_EN
    logic [7:0] lfsr_q, lfsr_d;
    // Fibonacci taps 8,6,5,4
    assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign wready_ok = lfsr_q[0];
    assign rvalid_ok = lfsr_d[1];

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 8'hA5;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign wready_ok = 1'b1;
    assign rvalid_ok = 1'b1;
`endif

    always_comb begin
        wstate_d  = wstate_q;
        wid_d     = wid_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wfixed_d  = wfixed_q;
        werr_d    = werr_q;
        wover_d   = wover_q;
        mem_we    = 1'b0;
        mem_waddr = widx_q;
        mem_wdata = axi.in_mosi_i.wdata;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                awready = 1'b1;
                if (axi.in_mosi_i.awvalid) begin
                    wid_d    = axi.in_mosi_i.awid;
                    widx_d   = to_idx(axi.in_mosi_i.awaddr);
                    wlen_d   = axi.in_mosi_i.awlen;
                    wfixed_d = (axi.in_mosi_i.awburst == 2'b00);
                    werr_d   = axi.in_mosi_i.awburst[1];
                    wcnt_d   = 8'd0;
                    wover_d  = 1'b0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = wready_ok;
                if (axi.in_mosi_i.wvalid && wready) begin
                    // wover_q marks beats past AWLEN+1: accepted but never written
                    mem_we = axi.in_mosi_i.wstrb && !wover_q;
                    widx_d = next_idx(widx_q, wfixed_q);
                    wcnt_d = wcnt_q + 8'd1;
                    if (wover_q) werr_d = 1'b1;
                    if (axi.in_mosi_i.wlast) begin
                        if (wcnt_q != wlen_q) werr_d = 1'b1;
                        wstate_d = W_RESP;
                    end else if (wcnt_q == wlen_q) begin
                        wover_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (axi.in_mosi_i.bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        ridx_d   = ridx_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        rfixed_d = rfixed_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        arready  = 1'b0;
        rnext    = next_idx(ridx_q, rfixed_q);
        unique case (rstate_q)
            R_IDLE: begin
                arready = 1'b1;
                if (axi.in_mosi_i.arvalid) begin
                    rid_d    = axi.in_mosi_i.arid;
                    ridx_d   = to_idx(axi.in_mosi_i.araddr);
                    rlen_d   = axi.in_mosi_i.arlen;
                    rcnt_d   = 8'd0;
                    rfixed_d = (axi.in_mosi_i.arburst == 2'b00);
                    rresp_d  = axi.in_mosi_i.arburst[1] ? 2'b10 : 2'b00;
                    rdata_d  = mem_q[to_idx(axi.in_mosi_i.araddr)];
                    rlast_d  = (axi.in_mosi_i.arlen == 8'd0);
                    rvalid_d = rvalid_ok;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && axi.in_mosi_i.rready) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        rstate_d = R_IDLE;
                    end else begin
                        // next beat is prefetched here; the array read sees pre-write data
                        ridx_d   = rnext;
                        rcnt_d   = rcnt_q + 8'd1;
                        rdata_d  = mem_q[rnext];
                        rlast_d  = (rcnt_q + 8'd1 == rlen_q);
                        rvalid_d = rvalid_ok;
                    end
                end else if (!rvalid_q) begin
                    rvalid_d = rvalid_ok;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            wid_q    <= '0;
            widx_q   <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wfixed_q <= 1'b0;
            werr_q   <= 1'b0;
            wover_q  <= 1'b0;
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            ridx_q   <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rfixed_q <= 1'b0;
            rresp_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wid_q    <= wid_d;
            widx_q   <= widx_d;
            wlen_q   <= wlen_d;
            wcnt_q   <= wcnt_d;
            wfixed_q <= wfixed_d;
            werr_q   <= werr_d;
            wover_q  <= wover_d;
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            ridx_q   <= ridx_d;
            rlen_q   <= rlen_d;
            rcnt_q   <= rcnt_d;
            rfixed_q <= rfixed_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
        end
    end

    always_comb begin
        axi.out_miso_o         = '0;
        axi.out_miso_o.awready = awready;
        axi.out_miso_o.wready  = wready;
        axi.out_miso_o.bid     = wid_q;
        axi.out_miso_o.bresp   = {werr_q, 1'b0};
        axi.out_miso_o.bvalid  = bvalid;
        axi.out_miso_o.arready = arready;
        axi.out_miso_o.rid     = rid_q;
        axi.out_miso_o.rdata   = rdata_q;
        axi.out_miso_o.rresp   = rresp_q;
        axi.out_miso_o.rlast   = rlast_q;
        axi.out_miso_o.rvalid  = rvalid_q;
    end
endmodule

// File: tb/tb_sr_axi_mem_responder.sv
// Directed bench for sr_axi_mem_responder with a byte-array reference model
// and B/R scoreboards.
module tb_sr_axi_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  aw_id = '0;
    logic [15:0] aw_addr = '0;
    logic [7:0]  aw_len = '0;
    logic [1:0]  aw_burst = '0;
    logic        aw_valid = 1'b0;
    logic [7:0]  w_data = '0;
    logic        w_strb = 1'b0, w_last = 1'b0, w_valid = 1'b0, b_ready = 1'b0;
    logic [3:0]  ar_id = '0;
    logic [15:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic [1:0]  ar_burst = '0;
    logic        ar_valid = 1'b0, r_ready = 1'b0;

    sr_axi_mem_responder_if bus ();

    assign bus.in_mosi_i = {aw_id, aw_addr, aw_len, aw_burst, aw_valid,
                            w_data, w_strb, w_last, w_valid, b_ready,
                            ar_id, ar_addr, ar_len, ar_burst, ar_valid, r_ready};

    sr_axi_mem_responder dut (.clk(clk), .rst(rst), .axi(bus));

    int checks = 0;
    int errors = 0;
    logic [7:0]  model_mem [4096];
    logic [5:0]  exp_b_q [$];
    logic [14:0] exp_r_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats, input logic [31:0] dat);
        logic [11:0] idx;
        logic [5:0]  exp;
        logic        err;
        idx = addr[11:0];
        err = burst[1] || (nbeats != int'(len) + 1);
        @(negedge clk);
        aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst; aw_valid = 1'b1;
        for (int i = 0; i < 200 && !bus.out_miso_o.awready; i++) @(negedge clk);
        chk("awready", 32'(bus.out_miso_o.awready), 32'd1);
        exp_b_q.push_back({id, err, 1'b0});
        @(negedge clk);
        aw_valid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            w_data = dat[8*b +: 8]; w_strb = 1'b1; w_last = (b == nbeats - 1); w_valid = 1'b1;
            for (int i = 0; i < 200 && !bus.out_miso_o.wready; i++) @(negedge clk);
            chk("wready", 32'(bus.out_miso_o.wready), 32'd1);
            if (b <= int'(len)) model_mem[idx] = w_data;
            if (burst != 2'b00) idx = idx + 12'd1;
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < 200 && !bus.out_miso_o.bvalid; i++) @(negedge clk);
        chk("bvalid", 32'(bus.out_miso_o.bvalid), 32'd1);
        exp = exp_b_q.pop_front();
        chk("bid", 32'(bus.out_miso_o.bid), 32'(exp[5:2]));
        chk("bresp", 32'(bus.out_miso_o.bresp), 32'(exp[1:0]));
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int stall);
        logic [11:0] idx;
        logic [14:0] exp;
        idx = addr[11:0];
        for (int b = 0; b <= int'(len); b++) begin
            exp_r_q.push_back({id, burst[1], 1'b0, (b == int'(len)), model_mem[idx]});
            if (burst != 2'b00) idx = idx + 12'd1;
        end
        @(negedge clk);
        ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst; ar_valid = 1'b1;
        for (int i = 0; i < 200 && !bus.out_miso_o.arready; i++) @(negedge clk);
        chk("arready", 32'(bus.out_miso_o.arready), 32'd1);
        @(negedge clk);
        ar_valid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            exp = exp_r_q.pop_front();
            for (int i = 0; i < 200 && !bus.out_miso_o.rvalid; i++) @(negedge clk);
            chk("rvalid", 32'(bus.out_miso_o.rvalid), 32'd1);
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    chk("stall_rvalid", 32'(bus.out_miso_o.rvalid), 32'd1);
                    chk("stall_rdata", 32'(bus.out_miso_o.rdata), 32'(exp[7:0]));
                    chk("stall_rlast", 32'(bus.out_miso_o.rlast), 32'(exp[8]));
                    @(negedge clk);
                end
            end
            r_ready = 1'b1;
            chk("rid", 32'(bus.out_miso_o.rid), 32'(exp[14:11]));
            chk("rresp", 32'(bus.out_miso_o.rresp), 32'(exp[10:9]));
            chk("rlast", 32'(bus.out_miso_o.rlast), 32'(exp[8]));
            chk("rdata", 32'(bus.out_miso_o.rdata), 32'(exp[7:0]));
            @(negedge clk);
            r_ready = 1'b0;
        end
        chk("rvalid_end", 32'(bus.out_miso_o.rvalid), 32'd0);
    endtask

    initial begin
        logic seen_b;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_awready", 32'(bus.out_miso_o.awready), 32'd1);
        chk("rst_arready", 32'(bus.out_miso_o.arready), 32'd1);
        chk("rst_wready", 32'(bus.out_miso_o.wready), 32'd0);
        chk("rst_bvalid", 32'(bus.out_miso_o.bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.out_miso_o.rvalid), 32'd0);
        chk("rst_rlast", 32'(bus.out_miso_o.rlast), 32'd0);
        chk("rst_bid_bresp", 32'({bus.out_miso_o.bid, bus.out_miso_o.bresp}), 32'd0);
        chk("rst_rid_rresp_rdata", 32'({bus.out_miso_o.rid, bus.out_miso_o.rresp, bus.out_miso_o.rdata}), 32'd0);

        // Reset in the middle of a write burst
        aw_id = 4'd5; aw_addr = 16'h0500; aw_len = 8'd3; aw_burst = 2'b01; aw_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0;
        w_data = 8'h5A; w_strb = 1'b1; w_last = 1'b0; w_valid = 1'b1;
        for (int i = 0; i < 200 && !bus.out_miso_o.wready; i++) @(negedge clk);
        @(negedge clk);
        w_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_awready", 32'(bus.out_miso_o.awready), 32'd1);
        chk("midrst_arready", 32'(bus.out_miso_o.arready), 32'd1);
        chk("midrst_bvalid", 32'(bus.out_miso_o.bvalid), 32'd0);
        chk("midrst_rvalid", 32'(bus.out_miso_o.rvalid), 32'd0);
        chk("midrst_wready", 32'(bus.out_miso_o.wready), 32'd0);
        b_ready = 1'b1;
        seen_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_miso_o.bvalid) seen_b = 1'b1;
            @(negedge clk);
        end
        b_ready = 1'b0;
        chk("midrst_no_b", 32'(seen_b), 32'd0);

        // Write then read back
        do_write(4'd2, 16'h1010, 8'd3, 2'b01, 4, 32'h44332211);
        do_read(4'd2, 16'h1010, 8'd3, 2'b01, 0);
        // Wrap-around past the top of the array
        do_write(4'd1, 16'h0FFE, 8'd3, 2'b01, 4, 32'hA4A3A2A1);
        do_read(4'd3, 16'h0000, 8'd1, 2'b01, 0);
        // Early WLAST over a prefilled region
        do_write(4'd4, 16'h0300, 8'd3, 2'b01, 4, 32'h04030201);
        do_write(4'd6, 16'h0300, 8'd3, 2'b01, 2, 32'h0000BBAA);
        do_read(4'd6, 16'h0300, 8'd3, 2'b01, 0);
        // FIXED burst and reserved burst type
        do_write(4'd8, 16'h0400, 8'd1, 2'b00, 2, 32'h0000C2C1);
        do_read(4'd8, 16'h0400, 8'd0, 2'b00, 0);
        do_write(4'd9, 16'h0410, 8'd1, 2'b11, 2, 32'h0000D2D1);
        do_read(4'd9, 16'h0410, 8'd1, 2'b11, 0);
        // Read stall concurrent with an unrelated write
        fork
            do_read(4'd7, 16'h1010, 8'd3, 2'b01, 5);
            do_write(4'd10, 16'h0600, 8'd1, 2'b01, 2, 32'h0000E2E1);
        join
        do_read(4'd11, 16'h0600, 8'd1, 2'b01, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
